// File: rtl/cpu_pkg.sv
// cpu_pkg: sequencer FSM states, branch_op encodings and the branch-condition helper
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_BLT  = 3'd3;
   localparam logic [2:0] BR_BGE  = 3'd4;
   localparam logic [2:0] BR_BLE  = 3'd5;
   localparam logic [2:0] BR_BGT  = 3'd6;
   function automatic logic br_cond(input logic [2:0] op, input logic zero, input logic less);
      return op == BR_BEQ ? zero :
             op == BR_BNE ? !zero :
             op == BR_BLT ? less :
             op == BR_BGE ? !less :
             op == BR_BLE ? (zero | less) :
             op == BR_BGT ? (!zero & !less) : 1'b0;
   endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection (jr > jump/jal > taken branch > pc+1)
module pc_next_sel import cpu_pkg::*; #(
   parameter int ADDR_W = 8,
   parameter int IMM_W  = 16
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [2:0]        branch_op,
   input  logic              jump,
   input  logic              jal,
   input  logic              jr,
   input  logic [IMM_W-1:0]  imm,
   input  logic [25:0]       jtarget,
   input  logic [31:0]       jr_target,
   input  logic              zero,
   input  logic              less,
   output logic [ADDR_W-1:0] next_pc,
   output logic              taken
);
   logic [ADDR_W+IMM_W-1:0] imm_ext;
   logic [ADDR_W-1:0]       seq_pc;
   logic                    unused_hi;
   assign seq_pc    = pc + ADDR_W'(1);
   // sign-extend past ADDR_W so the low slice works whether IMM_W is wider or narrower
   assign imm_ext   = {{ADDR_W{imm[IMM_W-1]}}, imm};
   assign next_pc   = jr ? jr_target[ADDR_W-1:0] :
                      (jump | jal) ? jtarget[ADDR_W-1:0] :
                      br_cond(branch_op, zero, less) ? seq_pc + imm_ext[ADDR_W-1:0] : seq_pc;
   assign taken     = next_pc != seq_pc;
   assign unused_hi = ^{jr_target, jtarget};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, fetch handshake FSM and next-PC update.
// Optional PC_PERF_CNT_EN adds saturating retired/redirect counters.
module pc_sequencer import cpu_pkg::*; #(
   parameter int                ADDR_W   = 8,
   parameter int                IMM_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              ex_done,
   input  logic [2:0]        branch_op,
   input  logic              jump,
   input  logic              jal,
   input  logic              jr,
   input  logic [IMM_W-1:0]  imm,
   input  logic [25:0]       jtarget,
   input  logic [31:0]       jr_target,
   input  logic              zero,
   input  logic              less,
   input  logic              halt,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_addr,
   output logic              taken,
   output logic              halted
`ifdef PC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [CNT_W-1:0]  redirect_cnt
`endif
);
   state_t            state, state_nx;
   logic [ADDR_W-1:0] next_pc;
   logic              sel_taken, accept, fetched;
   pc_next_sel #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) u_sel (
      .pc(pc), .branch_op(branch_op), .jump(jump), .jal(jal), .jr(jr), .imm(imm),
      .jtarget(jtarget), .jr_target(jr_target), .zero(zero), .less(less),
      .next_pc(next_pc), .taken(sel_taken)
   );
   assign accept      = state == EXEC && ex_done;
   assign fetched     = state == FETCH && imem_ack;
   assign imem_req    = state == FETCH;
   assign imem_addr   = pc;
   assign instr_valid = state == EXEC;
   assign halted      = state == HALT;
   assign link_addr   = pc + ADDR_W'(1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = FETCH;
         FETCH:   state_nx = fetched ? EXEC : FETCH;
         EXEC:    state_nx = accept ? (halt ? HALT : FETCH) : EXEC;
         default: state_nx = HALT;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pc    <= RESET_PC;
         instr <= '0;
         taken <= 1'b0;
      end else begin
         taken <= accept & sel_taken;
         if (fetched) instr <= imem_rdata;
         if (accept) pc <= next_pc;
      end
`ifdef PC_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         retired_cnt  <= '0;
         redirect_cnt <= '0;
      end else begin
         if (accept && !(&retired_cnt)) retired_cnt <= retired_cnt + CNT_W'(1);
         if (taken && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
`else
   localparam int cnt_w_unused = CNT_W;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table vectors, directed corner sequences and random stimulus vs a reference model
module tb_pc_sequencer;
   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] imm;
      logic        jump, jal, jr;
      logic [25:0] jt;
      logic [31:0] jrt;
      logic        zero, less, halt;
   } ctl_t;
   typedef struct packed {
      logic [7:0] setup;
      ctl_t       c;
      logic [7:0] exp_pc;
      logic       exp_tk;
   } vec_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic        imem_req, imem_ack = 1'b0, instr_valid, ex_done = 1'b0;
   logic [7:0]  imem_addr, pc, link_addr;
   logic [31:0] imem_rdata = '0, instr, jr_target = '0;
   logic [2:0]  branch_op = '0;
   logic        jump = 1'b0, jal = 1'b0, jr = 1'b0, zero = 1'b0, less = 1'b0, halt = 1'b0;
   logic [15:0] imm = '0;
   logic [25:0] jtarget = '0;
   logic        taken, halted;
`ifdef PC_PERF_CNT_EN
   logic [31:0] retired_cnt, redirect_cnt;
`endif

   int checks = 0, errors = 0, cyc = 0, req_cyc = 0, model_pc = 0, n_ret = 0, n_redir = 0;

   pc_sequencer dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .ex_done(ex_done),
      .branch_op(branch_op), .jump(jump), .jal(jal), .jr(jr), .imm(imm), .jtarget(jtarget),
      .jr_target(jr_target), .zero(zero), .less(less), .halt(halt), .pc(pc), .link_addr(link_addr),
      .taken(taken), .halted(halted)
`ifdef PC_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .redirect_cnt(redirect_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic ctl_t mk(int op, int im, bit j, bit jl, bit r, int jt, logic [31:0] jrt,
                               bit z, bit l, bit h);
      ctl_t c;
      c.op = 3'(op); c.imm = 16'(im); c.jump = j; c.jal = jl; c.jr = r;
      c.jt = 26'(jt); c.jrt = jrt; c.zero = z; c.less = l; c.halt = h;
      return c;
   endfunction

   // Reference: spec rules in plain integer arithmetic modulo 256
   function automatic int ref_next(int p, ctl_t c, output bit tk);
      bit cond;
      int n, seq;
      case (int'(c.op))
         1: cond = c.zero;
         2: cond = !c.zero;
         3: cond = c.less;
         4: cond = !c.less;
         5: cond = c.zero || c.less;
         6: cond = !c.zero && !c.less;
         default: cond = 0;
      endcase
      seq = (p + 1) % 256;
      if (c.jr) n = int'(c.jrt % 256);
      else if (c.jump || c.jal) n = int'(c.jt % 256);
      else if (cond) n = (p + 1 + int'($signed(c.imm))) & 255;
      else n = seq;
      tk = n != seq;
      return n;
   endfunction

   task automatic drive(input ctl_t c);
      branch_op = c.op; imm = c.imm; jump = c.jump; jal = c.jal; jr = c.jr;
      jtarget = c.jt; jr_target = c.jrt; zero = c.zero; less = c.less; halt = c.halt;
   endtask

   task automatic run_instr(input ctl_t c, input int lat, input int ex_wait);
      int n;
      bit tk;
      logic [31:0] w;
      n = 0;
      while (imem_req !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      chk("req_seen", 32'(imem_req), 1);
      if (imem_req !== 1'b1) return;
      req_cyc = cyc;
      chk("imem_addr", 32'(imem_addr), 32'(model_pc));
      for (int i = 0; i < lat; i++) begin
         ex_done = 1'($urandom); jump = 1'b1; jtarget = 26'($urandom);
         @(negedge clk);
         chk("req_hold", {imem_req, imem_addr}, {1'b1, 8'(model_pc)});
      end
      ex_done = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      w = $urandom;
      imem_ack = 1'b1; imem_rdata = w;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = $urandom;
      for (int i = 0; i < ex_wait; i++) begin
         imem_ack = 1'($urandom); imem_rdata = $urandom;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      chk("instr_valid", 32'(instr_valid), 1);
      chk("instr", instr, w);
      chk("link_addr", 32'(link_addr), 32'((model_pc + 1) % 256));
      drive(c); ex_done = 1'b1;
      @(negedge clk);
      ex_done = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      model_pc = ref_next(model_pc, c, tk);
      n_ret++;
      if (tk) n_redir++;
      chk("pc", 32'(pc), 32'(model_pc));
      chk("taken", 32'(taken), 32'(tk));
      chk("halted", 32'(halted), 32'(c.halt));
   endtask

   ctl_t nop, c;
   vec_t vecs[14];
   int prev, frozen;

   initial begin
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[0]  = '{8'd10,  mk(2, -3, 0, 0, 0, 0, 0, 0, 0, 0), 8'd8, 1'b1};
      vecs[1]  = '{8'd10,  mk(2, -3, 0, 0, 0, 0, 0, 1, 0, 0), 8'd11, 1'b0};
      vecs[2]  = '{8'd255, nop, 8'd0, 1'b0};
      vecs[3]  = '{8'd2,   mk(1, -5, 0, 0, 0, 0, 0, 1, 0, 0), 8'd254, 1'b1};
      vecs[4]  = '{8'd30,  mk(0, 0, 0, 1, 1, 'h99, 32'hFFFFFF05, 0, 0, 0), 8'd5, 1'b1};
      vecs[5]  = '{8'd250, mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0), 8'd5, 1'b1};
      vecs[6]  = '{8'd100, mk(3, 4, 0, 0, 0, 0, 0, 0, 1, 0), 8'd105, 1'b1};
      vecs[7]  = '{8'd100, mk(4, 4, 0, 0, 0, 0, 0, 0, 1, 0), 8'd101, 1'b0};
      vecs[8]  = '{8'd100, mk(5, -50, 0, 0, 0, 0, 0, 0, 0, 0), 8'd101, 1'b0};
      vecs[9]  = '{8'd100, mk(6, -50, 0, 0, 0, 0, 0, 0, 0, 0), 8'd51, 1'b1};
      vecs[10] = '{8'd100, mk(7, 9, 0, 0, 0, 0, 0, 1, 1, 0), 8'd101, 1'b0};
      vecs[11] = '{8'd7,   mk(0, 0, 1, 0, 0, 'h3FF12, 0, 0, 0, 0), 8'h12, 1'b1};
      vecs[12] = '{8'd60,  mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 8'd61, 1'b0};
      vecs[13] = '{8'd100, mk(5, 3, 0, 0, 0, 0, 0, 1, 0, 0), 8'd104, 1'b1};

      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_instr", instr, 0);
      chk("rst_outs", {imem_req, instr_valid, taken, halted}, 0);
      reset = 1'b1;

      // sequential fetch, 1-cycle ack latency: 3 cycles per instruction
      for (int i = 0; i < 4; i++) begin
         prev = req_cyc;
         run_instr(nop, 1, 0);
         if (i > 0) chk("t1_cycles", 32'(req_cyc - prev), 3);
      end

      foreach (vecs[i]) begin
         run_instr(mk(0, 0, 1, 0, 0, int'(vecs[i].setup), 0, 0, 0, 0), $urandom_range(0, 2), 0);
         run_instr(vecs[i].c, $urandom_range(0, 2), $urandom_range(0, 1));
         chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
         chk($sformatf("vec%0d_taken", i), 32'(taken), 32'(vecs[i].exp_tk));
      end

      // jal then jr back to the link address
      run_instr(mk(0, 0, 1, 0, 0, 20, 0, 0, 0, 0), 0, 0);
      chk("t4_link", 32'(link_addr), 21);
      run_instr(mk(0, 0, 0, 1, 0, 'h40, 0, 0, 0, 0), 1, 0);
      chk("t4_jal_pc", 32'(pc), 'h40);
      run_instr(mk(0, 0, 0, 0, 1, 0, 21, 0, 0, 0), 1, 1);
      chk("t4_jr_pc", 32'(pc), 21);

      for (int i = 0; i < 40; i++) begin
         c = mk($urandom_range(0, 7), ($urandom % 2) ? int'($urandom_range(0, 20)) - 10 : int'($urandom),
                ($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0, int'($urandom), $urandom,
                1'($urandom), 1'($urandom), 0);
         run_instr(c, $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // reset mid-fetch; a pending ack across reset release is discarded
      run_instr(mk(0, 0, 1, 0, 0, 33, 0, 0, 0, 0), 0, 0);
      chk("t5_pre_req", 32'(imem_req), 1);
      #2 reset = 1'b0;
      #1;
      chk("t5_async_req", 32'(imem_req), 0);
      chk("t5_async_pc", 32'(pc), 0);
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_fetch", {imem_req, instr_valid, imem_addr}, {1'b1, 1'b0, 8'd0});
      chk("t5_instr", instr, 0);
      imem_ack = 1'b0;
      model_pc = 0; n_ret = 0; n_redir = 0;
      run_instr(mk(1, 6, 0, 0, 0, 0, 0, 1, 0, 0), 2, 0);
      run_instr(nop, 1, 0);

      // halt: absorbing, pc frozen, handshakes ignored
      run_instr(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 0);
      frozen = model_pc;
      for (int i = 0; i < 100; i++) begin
         imem_ack = 1'($urandom); ex_done = 1'($urandom); jump = 1'($urandom); jtarget = 26'($urandom);
         @(negedge clk);
         chk("halt_state", {halted, imem_req, instr_valid, pc}, {1'b1, 1'b0, 1'b0, 8'(frozen)});
      end
      imem_ack = 1'b0; ex_done = 1'b0; jump = 1'b0;
`ifdef PC_PERF_CNT_EN
      chk("retired_cnt", retired_cnt, 32'(n_ret));
      chk("redirect_cnt", redirect_cnt, 32'(n_redir));
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
